// File: rtl/rf_wb_stage.sv
// rf_wb_stage: registered register-file write-back stage.
// Selects ALU, memory (acknowledge with timeout), immediate or bubble and
// issues one write-back pulse per accepted request.
// Optional feature macro: RF_WB_SEXT_EN adds imm_sext for sign-extended immediates.
module rf_wb_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IMM_W       = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  input  logic [IMM_W-1:0]  imm_data,
`ifdef RF_WB_SEXT_EN
  input  logic              imm_sext,
`endif
  output logic              wb_valid,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  localparam int unsigned CNT_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 1) ? CNT_RAW : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_err_q, wb_err_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] imm_ext_c;

  // Immediate extension to the data width
  always_comb begin
`ifdef RF_WB_SEXT_EN
    imm_ext_c = imm_sext ? DATA_W'($signed(imm_data)) : DATA_W'(imm_data);
`else
    imm_ext_c = DATA_W'(imm_data);
`endif
  end

  // Next-state, counter and write-back result selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    in_ready_d = 1'b0;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_err_d   = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          case (sel)
            2'b00: begin
              wb_valid_d = 1'b1;
              wb_we_d    = 1'b1;
              wb_addr_d  = rd_addr;
              wb_data_d  = alu_data;
            end
            2'b10: begin
              wb_valid_d = 1'b1;
              wb_we_d    = 1'b1;
              wb_addr_d  = rd_addr;
              wb_data_d  = imm_ext_c;
            end
            2'b11: begin
              wb_valid_d = 1'b1;
              wb_addr_d  = rd_addr;
              wb_data_d  = '0;
            end
            default: begin
              addr_d  = rd_addr;
              cnt_d   = '0;
              state_d = MEM_WAIT;
            end
          endcase
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b1;
          wb_addr_d  = addr_q;
          wb_data_d  = mem_data;
          state_d    = IDLE;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_TO)) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_addr_d  = addr_q;
          wb_data_d  = '0;
          state_d    = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_err_q   <= wb_err_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_err   = wb_err_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_rf_wb_stage.sv
// tb_rf_wb_stage: randomized self-checking bench for rf_wb_stage.
// Expected results come from a transaction-level model: result value by sel,
// memory latency = ack delay + 1, or MEM_TIMEOUT + 1 when the ack is too late.
module tb_rf_wb_stage;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned IMM_W       = 8;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned MEM_TIMEOUT = 15;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic [IMM_W-1:0]  imm_data;
  logic              imm_sext;
  logic              wb_valid;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;

  int n_chk;
  int n_pass;

  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  rf_wb_stage #(
    .DATA_W      (DATA_W),
    .IMM_W       (IMM_W),
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .rd_addr  (rd_addr),
    .alu_data (alu_data),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .imm_data (imm_data),
`ifdef RF_WB_SEXT_EN
    .imm_sext (imm_sext),
`endif
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_err   (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic we, input logic err,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chk({tag, ".valid"}, 32'(wb_valid), 32'(v));
    chk({tag, ".we"},    32'(wb_we),    32'(we));
    chk({tag, ".err"},   32'(wb_err),   32'(err));
    chk({tag, ".addr"},  32'(wb_addr),  32'(a));
    chk({tag, ".data"},  32'(wb_data),  32'(d));
  endtask

  // Quiet cycle: stray mem_ack allowed, outputs must hold with no pulse
  task automatic idle_cycle();
    in_valid = 1'b0;
    mem_ack  = 1'($urandom_range(0, 1));
    mem_data = DATA_W'($urandom);
    sel      = 2'($urandom);
    tick();
    mem_ack = 1'b0;
    chk_out("idle", 1'b0, 1'b0, 1'b0, last_addr, last_data);
  endtask

  // One request; ack_dly < 0 means the memory never acknowledges
  task automatic do_txn(input logic [1:0] s, input logic [ADDR_W-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] md,
                        input logic [IMM_W-1:0] imm, input logic sx, input int ack_dly);
    int            lat;
    int            val;
    logic          e_we;
    logic          e_err;
    logic [DATA_W-1:0] e_data;
    logic          sx_eff;
`ifdef RF_WB_SEXT_EN
    sx_eff = sx;
`else
    sx_eff = 1'b0;
`endif
    lat   = 1;
    e_we  = 1'b1;
    e_err = 1'b0;
    if (s == 2'b00) begin
      e_data = alu;
    end else if (s == 2'b10) begin
      val = int'(imm);
      if (sx_eff && (val >= (1 << (IMM_W - 1)))) val = val + (1 << DATA_W) - (1 << IMM_W);
      e_data = DATA_W'(val);
    end else if (s == 2'b11) begin
      e_we   = 1'b0;
      e_data = '0;
    end else if (ack_dly >= 0 && (MEM_TIMEOUT == 0 || ack_dly <= int'(MEM_TIMEOUT))) begin
      lat    = ack_dly + 1;
      e_data = md;
    end else begin
      lat    = int'(MEM_TIMEOUT) + 1;
      e_we   = 1'b0;
      e_err  = 1'b1;
      e_data = '0;
    end

    chk("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    sel      = s;
    rd_addr  = rd;
    alu_data = alu;
    imm_data = imm;
    imm_sext = sx;
    mem_ack  = 1'($urandom_range(0, 1));
    mem_data = ~md;
    tick();
    in_valid = 1'b0;
    mem_ack  = 1'b0;

    if (s == 2'b01) begin
      for (int c = 0; c < lat; c++) begin
        chk("wait.ready", 32'(in_ready), 32'd0);
        chk("wait.valid", 32'(wb_valid), 32'd0);
        in_valid = 1'($urandom_range(0, 1));
        sel      = 2'($urandom);
        rd_addr  = ADDR_W'($urandom);
        mem_ack  = (c == ack_dly);
        mem_data = (c == ack_dly) ? md : DATA_W'($urandom);
        tick();
      end
      in_valid = 1'b0;
      mem_ack  = 1'b0;
    end

    chk_out("wb", 1'b1, e_we, e_err, rd, e_data);
    last_addr = rd;
    last_data = e_data;
  endtask

  initial begin
    int rs;
    int ad;
    n_chk     = 0;
    n_pass    = 0;
    last_addr = '0;
    last_data = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sel       = 2'b00;
    rd_addr   = '0;
    alu_data  = '0;
    mem_data  = '0;
    mem_ack   = 1'b0;
    imm_data  = '0;
    imm_sext  = 1'b0;

    tick();
    tick();
    chk("rst.ready", 32'(in_ready), 32'd0);
    chk_out("rst", 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.ready", 32'(in_ready), 32'd1);
    chk("post_rst.valid", 32'(wb_valid), 32'd0);

    // ALU stream back to back
    do_txn(2'b00, 3'd1, 16'h1234, '0, '0, 1'b0, 0);
    do_txn(2'b00, 3'd2, 16'hBEEF, '0, '0, 1'b0, 0);
    do_txn(2'b00, 3'd3, 16'h0001, '0, '0, 1'b0, 0);
    idle_cycle();
    // Immediate, zero- and (if enabled) sign-extended
    do_txn(2'b10, 3'd4, '0, '0, 8'hA5, 1'b0, 0);
    do_txn(2'b10, 3'd4, '0, '0, 8'hA5, 1'b1, 0);
    do_txn(2'b10, 3'd6, '0, '0, 8'h5A, 1'b1, 0);
    // Memory with ack three cycles after accept
    do_txn(2'b01, 3'd5, '0, 16'hCAFE, '0, 1'b0, 3);
    // Timeout, then ack on the exact timeout cycle, then ack immediately
    do_txn(2'b01, 3'd7, '0, 16'h1111, '0, 1'b0, -1);
    do_txn(2'b01, 3'd2, '0, 16'h2222, '0, 1'b0, int'(MEM_TIMEOUT));
    do_txn(2'b01, 3'd3, '0, 16'h3333, '0, 1'b0, 0);
    // Bubble and stray acks in IDLE
    do_txn(2'b11, 3'd6, 16'hFFFF, '0, 8'hFF, 1'b0, 0);
    idle_cycle();
    idle_cycle();

    // Reset in the middle of a memory wait
    chk("rst2.ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    sel      = 2'b01;
    rd_addr  = 3'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst2.ready", 32'(in_ready), 32'd0);
    chk_out("rst2", 1'b0, 1'b0, 1'b0, '0, '0);
    mem_ack  = 1'b1;
    mem_data = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    last_addr = '0;
    last_data = '0;
    tick();
    chk("rst2.post_ready", 32'(in_ready), 32'd1);
    chk_out("rst2.post", 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cycle();

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      rs = int'($urandom_range(0, 7));
      if (rs == 0) ad = -1;
      else if (rs == 1) ad = int'(MEM_TIMEOUT);
      else ad = int'($urandom_range(0, MEM_TIMEOUT + 3));
      do_txn(2'($urandom), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
             IMM_W'($urandom), 1'($urandom_range(0, 1)), ad);
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_wb_stage.md
Name: rf_wb_stage

Overview:
- Registered, parametrised register-file write-back stage for the RISC processor.
- Selects among ALU result, memory read data and immediate data. Waits on a memory acknowledge with a timeout.
- Presents one write-back transaction (valid, write-enable, address, data) to the register file per accepted request.
- Sits between execute/memory and the register-file write port; replaces the purely combinational write-back mux.

Parameters:
- DATA_W, 16, register/data width.
- IMM_W, 8, immediate width; legal range 1..DATA_W.
- ADDR_W, 3, register address width.
- MEM_TIMEOUT, 15, max cycles to wait for mem_ack; 0 = wait forever.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- sel  input  2  00 ALU, 01 memory, 10 immediate, 11 bubble.
- rd_addr  input  ADDR_W  destination register.
- alu_data  input  DATA_W  ALU result.
- mem_data  input  DATA_W  memory read data, valid when mem_ack=1.
- mem_ack  input  1  memory data valid strobe.
- imm_data  input  IMM_W  immediate operand.
- wb_valid  output  1  one-cycle write-back pulse.
- wb_we  output  1  register-file write enable, qualified by wb_valid.
- wb_addr  output  ADDR_W  write address.
- wb_data  output  DATA_W  write data.
- wb_err  output  1  memory timeout flag, qualified by wb_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while rst_n=0, wb_valid=0, wb_we=0, wb_addr=0, wb_data=0, wb_err=0, timeout counter=0. in_ready=1 from the first clk edge after rst_n deasserts.
- States: IDLE, MEM_WAIT.
- Accept occurs on the edge where in_valid & in_ready; in_ready=1 only in IDLE.
- IDLE, accept, sel=00: next edge wb_valid=1, wb_we=1, wb_addr=rd_addr, wb_data=alu_data. Latency 1 cycle.
- IDLE, accept, sel=10: same, wb_data={zeros, imm_data} (zero-extended to DATA_W).
- IDLE, accept, sel=11: next edge wb_valid=1, wb_we=0, wb_data=0, wb_addr=rd_addr. Every sel code is defined; no latch.
- IDLE, accept, sel=01: capture rd_addr, clear counter, go to MEM_WAIT. mem_ack in the accept cycle is ignored.
- MEM_WAIT, mem_ack=1: next edge wb_valid=1, wb_we=1, wb_data=mem_data, wb_err=0, go to IDLE. Latency N+1 cycles when the ack arrives N cycles after accept.
- MEM_WAIT, no ack: counter increments each cycle. When the counter reaches MEM_TIMEOUT (MEM_TIMEOUT>0), next edge wb_valid=1, wb_we=0, wb_err=1, wb_data=0, go to IDLE.
- Ack and timeout on the same cycle: the ack wins (data written, wb_err=0).
- wb_valid, wb_we and wb_err are one-cycle pulses; all drop to 0 the following cycle unless a new result completes.
- wb_addr and wb_data hold their last values when wb_valid=0.
- Back-to-back: in_ready stays 1 in IDLE, so ALU/IMM requests sustain one write-back per cycle.
- mem_ack while in IDLE is ignored.
- Counter width is clog2(MEM_TIMEOUT+1), minimum 1; it saturates, never wraps.
- Reset mid-MEM_WAIT: the transaction is dropped, no wb_valid is issued, and the stage returns to IDLE.

Optional Feature:
- Macro RF_WB_SEXT_EN.
- Defined: adds input port imm_sext (1 bit, sampled at accept). For sel=10 with imm_sext=1, wb_data is imm_data sign-extended from bit IMM_W-1; with imm_sext=0 it is zero-extended.
- Undefined: port absent; the immediate is always zero-extended.

Test Plan:
- Reset: rst_n=0 mid-MEM_WAIT -> all outputs 0 immediately. After release, in_ready=1 and no stray wb_valid.
- ALU stream: accept sel=00 with alu_data 0x1234, 0xBEEF, 0x0001 on consecutive cycles -> three consecutive wb_valid pulses, wb_we=1, data in order, latency 1.
- Immediate: sel=10, imm_data=0xA5 -> wb_data=0x00A5. With RF_WB_SEXT_EN and imm_sext=1 -> 0xFFA5.
- Memory: sel=01, rd_addr=5, mem_ack 3 cycles later with mem_data=0xCAFE -> wb_valid 4 cycles after accept, wb_addr=5, wb_data=0xCAFE, in_ready=0 throughout the wait.
- Timeout: sel=01, no ack, MEM_TIMEOUT=15 -> wb_valid with wb_we=0, wb_err=1 after the counter reaches 15. Repeat with the ack on the exact timeout cycle -> data written, wb_err=0.
- Bubble: sel=11 -> wb_valid=1, wb_we=0, wb_data=0. mem_ack pulsed in IDLE -> no effect.
